// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG stream reader: register map, FSM states,
// bus byte-swap helper and EOI marker bytes.
package jpeg_pkg;
  localparam logic [2:0] REG_SRC   = 3'd0;
  localparam logic [2:0] REG_LEN   = 3'd1;
  localparam logic [2:0] REG_CTRL  = 3'd2;
  localparam logic [2:0] REG_COUNT = 3'd3;
  localparam logic [2:0] REG_ABORT = 3'd4;

  localparam logic [7:0] EOI_B0 = 8'hFF;
  localparam logic [7:0] EOI_B1 = 8'hD9;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} rd_state_t;

  function automatic logic [31:0] byteswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction
endpackage

// File: rtl/jpeg_word_fifo.sv
// Synchronous FIFO of 16-bit words with a 2-bit byte-valid mask per entry.
// Caller never pushes when full or pops when empty; flush wins over push/pop.
module jpeg_word_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [15:0]                push_data,
  input  logic [1:0]                 push_mask,
  input  logic                       pop,
  output logic [15:0]                head_data,
  output logic [1:0]                 head_mask,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][17:0] mem;
  logic [AW-1:0] wp, rp;

  always_ff @(posedge clk)
    if (push) mem[wp] <= {push_mask, push_data};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[rp][15:0];
  assign head_mask = mem[rp][17:16];
  assign empty     = (count == '0);
endmodule

// File: rtl/jpeg_stream_reader.sv
// DMA reader: fetches a JPEG byte stream over a 16-bit Avalon-MM master and
// emits it as a byte stream. Optional JPEG_EOI_DETECT_EN stops at FF D9.
module jpeg_stream_reader import jpeg_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  input  logic        m_waitrequest,
  output logic [30:0] m_address,
  output logic        m_read,
  input  logic [15:0] m_readdata,
  output logic [1:0]  m_byteenable,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_t   state;
  logic [31:0] src, len, cur_addr, remaining, count, wval, consume, nxt_addr;
  logic        busy, lo_done;
  logic        wr_src, wr_len, wr_ctrl, wr_abort, start_ok;
  logic [15:0] head_data;
  logic [1:0]  head_mask, pend, new_mask;
  logic [CW-1:0] f_count;
  logic        f_empty, xfer, pop, push, flush, halt, rd_ack, last_word, room_next, eoi_hit;

  assign wval     = byteswap32(s_writedata);
  assign wr_src   = s_write && (s_address == REG_SRC);
  assign wr_len   = s_write && (s_address == REG_LEN);
  assign wr_ctrl  = s_write && (s_address == REG_CTRL);
  assign wr_abort = s_write && (s_address == REG_ABORT);
  // A read still in flight after an abort/EOI owns the bus; hold off new starts.
  assign start_ok = wr_ctrl && (state == IDLE) && !busy && !m_read;

  always_comb begin
    s_readdata = 32'h0;
    if (s_read)
      case (s_address)
        REG_SRC:   s_readdata = byteswap32(src);
        REG_LEN:   s_readdata = byteswap32(len);
        REG_CTRL:  s_readdata = byteswap32({31'b0, busy});
        REG_COUNT: s_readdata = byteswap32(count);
        default:   s_readdata = byteswap32(32'hdeadbeef);
      endcase
  end

  // Byte mask and byte consumption of the word at cur_addr.
  always_comb begin
    new_mask = 2'b11;
    consume  = 32'd2;
    if (cur_addr[0]) begin
      new_mask = 2'b10;
      consume  = 32'd1;
    end else if (remaining == 32'd1) begin
      new_mask = 2'b01;
      consume  = 32'd1;
    end
  end
  assign nxt_addr  = cur_addr + consume;
  assign last_word = (remaining == consume);

  assign pend      = head_mask & ~{1'b0, lo_done};
  assign out_valid = !f_empty;
  assign out_data  = pend[0] ? head_data[7:0] : head_data[15:8];
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (pend != 2'b11);
  assign rd_ack    = m_read && !m_waitrequest;
  assign halt      = wr_abort || eoi_hit;
  assign flush     = halt;
  assign push      = rd_ack && (state == FETCH) && !halt;
  assign room_next = (int'(f_count) + 1 - int'(pop)) < FIFO_DEPTH;
  assign m_byteenable = 2'b11;

`ifdef JPEG_EOI_DETECT_EN
  logic prev_ff;
  always_ff @(posedge clk)
    if (rst || start_ok) prev_ff <= 1'b0;
    else if (xfer)       prev_ff <= (out_data == EOI_B0);
  assign eoi_hit = xfer && prev_ff && (out_data == EOI_B1) &&
                   (state == FETCH || state == DRAIN);
`else
  assign eoi_hit = 1'b0;
`endif

  jpeg_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push(push), .push_data(m_readdata), .push_mask(new_mask),
    .pop(pop), .head_data(head_data), .head_mask(head_mask),
    .count(f_count), .empty(f_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src       <= '0;
      len       <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      count     <= '0;
      busy      <= 1'b0;
      lo_done   <= 1'b0;
      m_read    <= 1'b0;
      m_address <= '0;
      irq       <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (wr_src && !busy) src <= wval;
      if (wr_len && !busy) len <= wval;
      if (xfer) begin
        count   <= count + 32'd1;
        lo_done <= !pop;
      end
      if (flush) lo_done <= 1'b0;
      if (rd_ack) m_read <= 1'b0;
      case (state)
        IDLE: if (start_ok) begin
          count <= '0;
          if (len == 32'd0) state <= DONE;
          else begin
            cur_addr  <= src;
            remaining <= len;
            busy      <= 1'b1;
            m_read    <= 1'b1;
            m_address <= src[31:1];
            state     <= FETCH;
          end
        end
        FETCH: if (rd_ack) begin
          cur_addr  <= nxt_addr;
          remaining <= remaining - consume;
          m_address <= nxt_addr[31:1];
          if (last_word) state <= DRAIN;
          else           m_read <= room_next;
        end else if (!m_read && int'(f_count) < FIFO_DEPTH) begin
          m_read <= 1'b1;
        end
        DRAIN: if (f_empty) state <= DONE;
        DONE: begin
          irq   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Abort/EOI: stop issuing, but an in-flight read completes on the bus.
      if (halt) begin
        m_read <= m_read && !rd_ack;
        if (wr_abort) begin
          state <= IDLE;
          busy  <= 1'b0;
          irq   <= 1'b0;
        end else begin
          state <= DONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_jpeg_stream_reader.sv
// Directed bench for jpeg_stream_reader: memory model with stall control,
// stream sink with ready patterns, byte/read/irq monitors.
module tb_jpeg_stream_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata, s_readdata;
  logic        m_waitrequest;
  logic [30:0] m_address;
  logic        m_read;
  logic [15:0] m_readdata;
  logic [1:0]  m_byteenable;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic        irq;

  jpeg_stream_reader #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_waitrequest(m_waitrequest), .m_address(m_address), .m_read(m_read),
    .m_readdata(m_readdata), .m_byteenable(m_byteenable),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, wcnt = 0, n_acc = 0;
  int stall_n = 0, hold_base = 0, rmode = 0;
  logic hold_rd = 1'b0;
  logic [15:0] mem [0:63];

  logic [30:0] rd_q[$];
  logic [7:0]  by_q[$];
  int          by_cyc[$];
  int irq_cnt = 0, irq_cyc = 0, addr_viol = 0, data_viol = 0;
  logic        prev_rs = 1'b0, prev_os = 1'b0;
  logic [30:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  int          wr_cyc, rd0, by0, irq0;
  logic        lat_m_read;
  logic [31:0] v;

  // Memory slave: stall_n wait cycles per read, optional hold after first accept.
  assign m_waitrequest = m_read && ((hold_rd && n_acc > hold_base) || wcnt < stall_n);
  assign m_readdata    = mem[m_address[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_read && !m_waitrequest) begin
      wcnt  <= 0;
      n_acc <= n_acc + 1;
    end else if (m_read) wcnt <= wcnt + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_read && !m_waitrequest) rd_q.push_back(m_address);
      if (out_valid && out_ready) begin
        by_q.push_back(out_data);
        by_cyc.push_back(cyc);
      end
      if (irq) begin
        irq_cnt <= irq_cnt + 1;
        irq_cyc <= cyc;
      end
      if (prev_rs && (!m_read || m_address != prev_addr)) addr_viol <= addr_viol + 1;
      if (prev_os && out_valid && out_data != prev_data) data_viol <= data_viol + 1;
      prev_rs   <= m_read && m_waitrequest;
      prev_addr <= m_address;
      prev_os   <= out_valid && !out_ready;
      prev_data <= out_data;
    end
  end

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] val);
    s_address   = a;
    s_writedata = bswap(val);
    s_write     = 1'b1;
    wr_cyc      = cyc;
    tick();
    s_write     = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] val);
    s_address = a;
    s_read    = 1'b1;
    #1;
    val       = bswap(s_readdata);
    s_read    = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] len,
                          input int budget);
    reg_write(3'd0, src);
    reg_write(3'd1, len);
    rd0 = rd_q.size(); by0 = by_q.size(); irq0 = irq_cnt;
    reg_write(3'd2, 32'd1);
    lat_m_read = m_read;
    for (int i = 0; i < budget; i++) begin
      if (irq_cnt != irq0) break;
      tick();
    end
    check({tag, "_done"}, 32'(irq_cnt != irq0), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = {8'(2*i + 2), 8'(2*i + 1)};
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_m_read", 32'(m_read), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reg_read(3'd2, v); check("rst_busy", v, 32'd0);
    reg_read(3'd3, v); check("rst_count", v, 32'd0);
    reg_read(3'd6, v); check("bad_reg", v, 32'hdeadbeef);

    // 1: aligned 8 bytes
    run_xfer("t1", 32'h1000, 32'd8, 200);
    check("t1_lat", 32'(lat_m_read), 32'd1);
    reg_read(3'd0, v); check("t1_src", v, 32'h1000);
    check("t1_nbytes", 32'(by_q.size() - by0), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t1_b%0d", i), 32'(by_q[by0+i]), 32'(i + 1));
    check("t1_nreads", 32'(rd_q.size() - rd0), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_a%0d", i), 32'(rd_q[rd0+i]), 32'(32'h800 + i));
    reg_read(3'd3, v); check("t1_count", v, 32'd8);
    check("t1_irqs", 32'(irq_cnt - irq0), 32'd1);
    reg_read(3'd2, v); check("t1_busy", v, 32'd0);

    // 2: odd source, 4 bytes
    run_xfer("t2", 32'h1001, 32'd4, 200);
    check("t2_nbytes", 32'(by_q.size() - by0), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_b%0d", i), 32'(by_q[by0+i]), 32'(i + 2));
    check("t2_nreads", 32'(rd_q.size() - rd0), 32'd3);
    check("t2_nobubble", 32'(by_cyc[by0+3] - by_cyc[by0]), 32'd3);
    reg_read(3'd3, v); check("t2_count", v, 32'd4);

    // 3: zero length
    run_xfer("t3", 32'h2000, 32'd0, 20);
    check("t3_nreads", 32'(rd_q.size() - rd0), 32'd0);
    check("t3_irq_lat", 32'(irq_cyc - wr_cyc), 32'd2);
    check("t3_irqs", 32'(irq_cnt - irq0), 32'd1);
    reg_read(3'd3, v); check("t3_count", v, 32'd0);

    // 4: stalled reads, toggling ready, SRC write while busy ignored
    stall_n = 5; rmode = 1;
    reg_write(3'd0, 32'h1000);
    reg_write(3'd1, 32'd8);
    rd0 = rd_q.size(); by0 = by_q.size(); irq0 = irq_cnt;
    reg_write(3'd2, 32'd1);
    repeat (4) tick();
    reg_write(3'd0, 32'habcd);
    for (int i = 0; i < 400; i++) begin
      if (irq_cnt != irq0) break;
      tick();
    end
    check("t4_done", 32'(irq_cnt != irq0), 32'd1);
    repeat (3) tick();
    check("t4_nbytes", 32'(by_q.size() - by0), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t4_b%0d", i), 32'(by_q[by0+i]), 32'(i + 1));
    check("t4_nreads", 32'(rd_q.size() - rd0), 32'd4);
    check("t4_addr_stable", 32'(addr_viol), 32'd0);
    check("t4_data_stable", 32'(data_viol), 32'd0);
    reg_read(3'd0, v); check("t4_src_locked", v, 32'h1000);
    reg_read(3'd3, v); check("t4_count", v, 32'd8);
    stall_n = 0; rmode = 0;

    // 5: abort while the second read is stalled
    rmode = 2; hold_base = n_acc; hold_rd = 1'b1;
    reg_write(3'd0, 32'h1000);
    reg_write(3'd1, 32'd8);
    irq0 = irq_cnt;
    reg_write(3'd2, 32'd1);
    repeat (3) tick();
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    check("t5_pre_mread", 32'(m_read), 32'd1);
    reg_write(3'd4, 32'd1);
    check("t5_held_mread", 32'(m_read), 32'd1);
    check("t5_flushed", 32'(out_valid), 32'd0);
    reg_read(3'd2, v); check("t5_busy", v, 32'd0);
    hold_rd = 1'b0;
    repeat (3) tick();
    check("t5_mread_off", 32'(m_read), 32'd0);
    check("t5_discard", 32'(out_valid), 32'd0);
    check("t5_no_irq", 32'(irq_cnt - irq0), 32'd0);
    rmode = 0;
    run_xfer("t5b", 32'h1002, 32'd2, 100);
    check("t5b_nbytes", 32'(by_q.size() - by0), 32'd2);
    check("t5b_b0", 32'(by_q[by0]), 32'h03);
    check("t5b_b1", 32'(by_q[by0+1]), 32'h04);
    reg_read(3'd3, v); check("t5b_count", v, 32'd2);

`ifdef JPEG_EOI_DETECT_EN
    // 6: EOI marker split across words
    for (int i = 0; i < 64; i++) mem[i] = 16'h0101;
    mem[0] = 16'h1110; mem[1] = 16'hFF12; mem[2] = 16'h55D9; mem[3] = 16'h5756;
    run_xfer("t6", 32'h1000, 32'd64, 300);
    begin
      int rd_at_end = rd_q.size();
      check("t6_nbytes", 32'(by_q.size() - by0), 32'd5);
      check("t6_last", 32'(by_q[by_q.size()-1]), 32'hD9);
      reg_read(3'd3, v); check("t6_count", v, 32'd5);
      repeat (10) tick();
      check("t6_no_more_reads", 32'(rd_q.size()), 32'(rd_at_end));
      check("t6_valid", 32'(out_valid), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
